dcpu_sysbus: RTL and testbench
==============================

Name: dcpu_sysbus

Overview:
System bus slave that sits directly downstream of the dcpu core's memory port (o_addr/o_dat/o_we/o_cs in, i_dat/i_ack out), and feeds the core's i_irq.
- Decodes each access to one of three regions: on-chip RAM, a small I/O register page (interval timer and GPIO output latch), or unmapped space.
- Generates the single-cycle ack handshake with configurable RAM wait states.
- Drives the core's interrupt line from the timer.

Parameters:
W, 16, data/address width
AW, 12, RAM address bits; RAM holds 2^AW words at 0x0000..(2^AW - 1)
RAM_WAIT, 1, extra wait cycles for a RAM access (0..7)
IO_PAGE, 8'hFF, value of addr[15:8] that selects the I/O page

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_addr  in  W  address from core o_addr
i_dat  in  W  write data from core o_dat
i_we  in  1  write enable from core o_we
i_cs  in  1  request from core o_cs
o_dat  out  W  read data to core i_dat; valid only while o_ack=1
o_ack  out  1  one-cycle completion pulse to core i_ack
o_irq  out  1  interrupt request to core i_irq (level)
o_gpio  out  W  GPIO output latch

Behaviour:
- Reset values, applied while i_reset=1 and overriding everything else:
  - FSM=IDLE; o_ack=0, o_dat=0, o_irq=0, o_gpio=0.
  - Timer count, compare and control all 0.
  - RAM contents are not reset.
- FSM states are IDLE, BUSY, ACK.
- IDLE:
  - When i_cs=1, latch addr, we, wdata and region.
  - Load the wait counter with RAM_WAIT for RAM accesses, or 0 for I/O and unmapped.
  - Go to BUSY if the loaded count is >0, else go to ACK.
- BUSY: decrement the counter each cycle; go to ACK when it reaches 0.
- ACK:
  - o_ack=1 for exactly one cycle, with o_dat valid in that cycle.
  - A write commits in this cycle.
  - Next state is IDLE.
  - A request still present on i_cs in the following cycle is treated as a new access.
- Latency, counted from the cycle i_cs is first sampled in IDLE:
  - o_ack rises RAM_WAIT+1 cycles later for RAM.
  - o_ack rises 1 cycle later for I/O and unmapped.
  - Back-to-back accesses take a minimum of 2 cycles each.
- Abort: if i_cs=0 in BUSY or ACK, return to IDLE with o_ack=0. No write is committed.
- Reset mid-access: the FSM returns to IDLE immediately. No ack, no write.
- Region decode:
  - RAM when addr[W-1:AW]==0.
  - I/O when addr[15:8]==IO_PAGE. RAM decode has priority if the two regions overlap.
  - Anything else is unmapped: reads return 0, writes are dropped, and it still acks.
- RAM is synchronous single-port. The read address is registered at latch, and the data is held until ACK.
- I/O registers are selected by offset addr[7:0]:
  - 0x00 TCOUNT, R/W.
  - 0x01 TCMP, R/W.
  - 0x02 TCTRL:
    - bit0 EN, R/W.
    - bit1 IE, R/W.
    - bit2 PEND: reads the flag; writing 1 clears it, writing 0 has no effect.
    - Other bits read 0.
  - 0x03 GPIO, R/W, drives o_gpio.
  - Offsets 0x04..0xFF read 0; writes to them are ignored.
- Timer:
  - While EN=1, each cycle: if TCOUNT==TCMP then TCOUNT<=0 and PEND<=1, else TCOUNT<=TCOUNT+1 (mod 2^W).
  - With TCMP=0 it fires every cycle.
  - While EN=0, TCOUNT holds.
- Simultaneous timer and software events:
  - A software write to TCOUNT in the same cycle as a timer tick: the write wins.
  - A PEND set by the timer and a W1C clear in the same cycle: the set wins.
- o_irq is registered: o_irq <= PEND & IE, so it rises one cycle after PEND rises.

Decomposition:
- Shared package dcpu_pkg holds:
  - the FSM state enum;
  - I/O offsets TCOUNT/TCMP/TCTRL/GPIO;
  - TCTRL bit positions;
  - default IO_PAGE;
  - the region-select enum RAM/IO/NONE.
- One natural sub-module is dcpu_timer, which owns TCOUNT, TCMP, TCTRL and o_irq. Its interface is a write strobe, an offset, wdata and rdata.
- RAM is an inferred array inside dcpu_sysbus.

Test Plan:
- RAM_WAIT=1: write 0x1234 to 0x0010, then read 0x0010 → each o_ack pulses exactly 2 cycles after i_cs rises; read returns o_dat=0x1234.
- RAM_WAIT=0: read 0x0020 held on i_cs for 4 cycles → acks in cycles 1 and 3. Access to unmapped 0x8000 (AW=12) → ack after 1 cycle, o_dat=0; a write there does not alter RAM 0x0000.
- Abort: start RAM write (RAM_WAIT=3), drop i_cs after 1 cycle → no o_ack; a later read of the same address shows the old value. The same with i_reset pulsed mid-access → FSM IDLE, no ack.
- Timer: TCMP=3, TCTRL=0x3 → PEND sets every 4 cycles; o_irq rises 1 cycle after PEND. Write TCTRL=0x7 → PEND clears, o_irq drops one cycle later.
- Collision: W1C of PEND in the exact cycle TCOUNT==TCMP → PEND remains 1. Write TCOUNT=0x0100 on a tick cycle → readback 0x0100 or 0x0101 depending on EN, never 0.
- GPIO: write 0xA5A5 to 0xFF03 → o_gpio=0xA5A5 the cycle after ack; readback 0xA5A5. Read 0xFF10 → 0.

Source files
------------

// File: rtl/dcpu_pkg.sv
// Shared types and constants for the dcpu system bus and its timer.
package dcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_IO   = 2'd1,
    RGN_NONE = 2'd2
  } region_e;

  localparam logic [7:0] OFF_TCOUNT = 8'h00;
  localparam logic [7:0] OFF_TCMP   = 8'h01;
  localparam logic [7:0] OFF_TCTRL  = 8'h02;
  localparam logic [7:0] OFF_GPIO   = 8'h03;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_IE   = 1;
  localparam int TCTRL_PEND = 2;

  localparam logic [7:0] IO_PAGE_DEFAULT = 8'hFF;

endpackage

// File: rtl/dcpu_timer.sv
// Interval timer: free-running compare counter with a sticky pending flag
// and a registered interrupt line.
module dcpu_timer
  import dcpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         wr_en,
  input  logic [7:0]   offset,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         irq
);

  logic [W-1:0] count_r;
  logic [W-1:0] cmp_r;
  logic         en_r;
  logic         ie_r;
  logic         pend_r;
  logic         irq_r;
  logic         tick_s;
  logic         wr_count_s;
  logic         wr_cmp_s;
  logic         wr_ctrl_s;
  logic [W-1:0] ctrl_rd_s;

  // strobe decode and compare match
  always_comb begin
    tick_s     = en_r && (count_r == cmp_r);
    wr_count_s = wr_en && (offset == OFF_TCOUNT);
    wr_cmp_s   = wr_en && (offset == OFF_TCMP);
    wr_ctrl_s  = wr_en && (offset == OFF_TCTRL);
  end

  // counter: a software write overrides the tick in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_r <= '0;
    end else if (wr_count_s) begin
      count_r <= wdata;
    end else if (tick_s) begin
      count_r <= '0;
    end else if (en_r) begin
      count_r <= count_r + W'(1);
    end
  end

  // compare and control registers; a timer set of PEND beats a W1C clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cmp_r  <= '0;
      en_r   <= 1'b0;
      ie_r   <= 1'b0;
      pend_r <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      if (wr_cmp_s) begin
        cmp_r <= wdata;
      end
      if (wr_ctrl_s) begin
        en_r <= wdata[TCTRL_EN];
        ie_r <= wdata[TCTRL_IE];
      end
      if (tick_s) begin
        pend_r <= 1'b1;
      end else if (wr_ctrl_s && wdata[TCTRL_PEND]) begin
        pend_r <= 1'b0;
      end
      irq_r <= pend_r & ie_r;
    end
  end

  // register read mux
  always_comb begin
    ctrl_rd_s             = '0;
    ctrl_rd_s[TCTRL_EN]   = en_r;
    ctrl_rd_s[TCTRL_IE]   = ie_r;
    ctrl_rd_s[TCTRL_PEND] = pend_r;
    case (offset)
      OFF_TCOUNT: rdata = count_r;
      OFF_TCMP:   rdata = cmp_r;
      OFF_TCTRL:  rdata = ctrl_rd_s;
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_r;

endmodule

// File: rtl/dcpu_sysbus.sv
// System bus slave for the dcpu core: RAM / I/O page / unmapped decode,
// wait-stated ack handshake, GPIO latch and timer interrupt.
module dcpu_sysbus
  import dcpu_pkg::*;
#(
  parameter int         W        = 16,
  parameter int         AW       = 12,
  parameter int         RAM_WAIT = 1,
  parameter logic [7:0] IO_PAGE  = IO_PAGE_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_dat,
  input  logic         i_we,
  input  logic         i_cs,
  output logic [W-1:0] o_dat,
  output logic         o_ack,
  output logic         o_irq,
  output logic [W-1:0] o_gpio
);

  logic [W-1:0]  ram_r [2**AW];
  bus_state_e    state_r;
  bus_state_e    next_state_s;
  region_e       region_s;
  region_e       region_r;
  logic [2:0]    wait_load_s;
  logic [2:0]    wait_cnt_r;
  logic [AW-1:0] ram_addr_r;
  logic [7:0]    io_off_r;
  logic [W-1:0]  wdata_r;
  logic          we_r;
  logic [W-1:0]  ram_rdata_r;
  logic [W-1:0]  gpio_r;
  logic [W-1:0]  tmr_rdata_s;
  logic [W-1:0]  rdata_s;
  logic          latch_s;
  logic          ack_s;
  logic          io_wr_s;

  // region decode; RAM wins if the I/O page overlaps it
  always_comb begin
    if (i_addr[W-1:AW] == '0) begin
      region_s = RGN_RAM;
    end else if (i_addr[W-1:W-8] == IO_PAGE) begin
      region_s = RGN_IO;
    end else begin
      region_s = RGN_NONE;
    end
    wait_load_s = (region_s == RGN_RAM) ? 3'(RAM_WAIT) : 3'd0;
    latch_s     = (state_r == ST_IDLE) && i_cs;
    // an ack (and its write) only happens while the core still requests
    ack_s       = (state_r == ST_ACK) && i_cs && !i_reset;
    io_wr_s     = ack_s && we_r && (region_r == RGN_IO);
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (i_cs) begin
          next_state_s = (wait_load_s != 3'd0) ? ST_BUSY : ST_ACK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!i_cs) begin
          next_state_s = ST_IDLE;
        end else if (wait_cnt_r <= 3'd1) begin
          next_state_s = ST_ACK;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_ACK:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs; read data is only driven during the ack cycle
  always_comb begin
    case (region_r)
      RGN_RAM: rdata_s = ram_rdata_r;
      RGN_IO:  rdata_s = (io_off_r == OFF_GPIO) ? gpio_r : tmr_rdata_s;
      default: rdata_s = '0;
    endcase
    o_ack = ack_s;
    if (ack_s) begin
      o_dat = rdata_s;
    end else begin
      o_dat = '0;
    end
  end

  // request latch and wait counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ram_addr_r <= '0;
      io_off_r   <= 8'h00;
      wdata_r    <= '0;
      we_r       <= 1'b0;
      region_r   <= RGN_NONE;
      wait_cnt_r <= 3'd0;
    end else if (latch_s) begin
      ram_addr_r <= i_addr[AW-1:0];
      io_off_r   <= i_addr[7:0];
      wdata_r    <= i_dat;
      we_r       <= i_we;
      region_r   <= region_s;
      wait_cnt_r <= wait_load_s;
    end else if (state_r == ST_BUSY) begin
      wait_cnt_r <= wait_cnt_r - 3'd1;
    end
  end

  // single-port synchronous RAM: read at latch, write at ack
  always_ff @(posedge i_clk) begin
    if (ack_s && we_r && (region_r == RGN_RAM)) begin
      ram_r[ram_addr_r] <= wdata_r;
    end
    if (latch_s && !i_reset) begin
      ram_rdata_r <= ram_r[i_addr[AW-1:0]];
    end
  end

  // GPIO output latch
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gpio_r <= '0;
    end else if (io_wr_s && (io_off_r == OFF_GPIO)) begin
      gpio_r <= wdata_r;
    end
  end

  dcpu_timer #(.W(W)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .wr_en   (io_wr_s),
    .offset  (io_off_r),
    .wdata   (wdata_r),
    .rdata   (tmr_rdata_s),
    .irq     (o_irq)
  );

  assign o_gpio = gpio_r;

endmodule

// File: tb/tb_dcpu_sysbus.sv
// Self-checking bench for dcpu_sysbus (RAM_WAIT=1, AW=12, IO_PAGE=0xFF).
module tb_dcpu_sysbus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic        we;
  logic        cs;
  logic [15:0] rdat;
  logic        ack;
  logic        irq;
  logic [15:0] gpio;

  dcpu_sysbus #(.W(16), .AW(12), .RAM_WAIT(1), .IO_PAGE(8'hFF)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_addr  (addr),
    .i_dat   (wdat),
    .i_we    (we),
    .i_cs    (cs),
    .o_dat   (rdat),
    .o_ack   (ack),
    .o_irq   (irq),
    .o_gpio  (gpio)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] dat;
    int          lat;
    bit          chk;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic [15:0] a;
    logic        w;
    logic [15:0] d;
    int          lat;
    bit          chk;
    logic [15:0] e;
  } vec_t;
  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // one bus access; expectation queued at drive time, compared at ack
  task automatic access(input string name, input logic [15:0] a, input logic w,
                        input logic [15:0] d, input int lat, input bit chk,
                        input logic [15:0] e);
    exp_t x;
    int   n;
    bit   got;
    @(negedge clk);
    addr = a; we = w; wdat = d; cs = 1'b1;
    sb_q.push_back('{dat: e, lat: lat, chk: chk});
    n = 0;
    got = 1'b0;
    while (!got && n < 16) begin
      @(negedge clk);
      n++;
      got = ack;
    end
    x = sb_q.pop_front();
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: no ack within 16 cycles", name);
    end else begin
      check({name, "_lat"}, 32'(n), 32'(x.lat));
      if (x.chk) check({name, "_dat"}, 32'(rdat), 32'(x.dat));
    end
    @(negedge clk);
    check({name, "_pulse"}, 32'(ack), 32'd0);
    cs = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{"ram_wr10",   16'h0010, 1'b1, 16'h1234, 2, 1'b0, 16'h0000};
    tbl[1]  = '{"ram_wr00",   16'h0000, 1'b1, 16'h5555, 2, 1'b0, 16'h0000};
    tbl[2]  = '{"ram_wrtop",  16'h0FFF, 1'b1, 16'hC3C3, 2, 1'b0, 16'h0000};
    tbl[3]  = '{"unm_wr8000", 16'h8000, 1'b1, 16'hDEAD, 1, 1'b0, 16'h0000};
    tbl[4]  = '{"unm_wr1000", 16'h1000, 1'b1, 16'h1111, 1, 1'b0, 16'h0000};
    tbl[5]  = '{"ram_rd10",   16'h0010, 1'b0, 16'h0000, 2, 1'b1, 16'h1234};
    tbl[6]  = '{"ram_rd00",   16'h0000, 1'b0, 16'h0000, 2, 1'b1, 16'h5555};
    tbl[7]  = '{"ram_rdtop",  16'h0FFF, 1'b0, 16'h0000, 2, 1'b1, 16'hC3C3};
    tbl[8]  = '{"unm_rd8000", 16'h8000, 1'b0, 16'h0000, 1, 1'b1, 16'h0000};
    tbl[9]  = '{"gpio_wr",    16'hFF03, 1'b1, 16'hA5A5, 1, 1'b0, 16'h0000};
    tbl[10] = '{"gpio_rd",    16'hFF03, 1'b0, 16'h0000, 1, 1'b1, 16'hA5A5};
    tbl[11] = '{"hole_wr",    16'hFF10, 1'b1, 16'hFFFF, 1, 1'b0, 16'h0000};
    tbl[12] = '{"hole_rd",    16'hFF10, 1'b0, 16'h0000, 1, 1'b1, 16'h0000};
    tbl[13] = '{"tcnt_wr",    16'hFF00, 1'b1, 16'h0042, 1, 1'b0, 16'h0000};
    tbl[14] = '{"tcnt_rd",    16'hFF00, 1'b0, 16'h0000, 1, 1'b1, 16'h0042};
    tbl[15] = '{"tctrl_wr",   16'hFF02, 1'b1, 16'hFFF8, 1, 1'b0, 16'h0000};
    tbl[16] = '{"tctrl_rd",   16'hFF02, 1'b0, 16'h0000, 1, 1'b1, 16'h0000};
    tbl[17] = '{"tcmp_wr",    16'hFF01, 1'b1, 16'h0007, 1, 1'b0, 16'h0000};
    tbl[18] = '{"tcmp_rd",    16'hFF01, 1'b0, 16'h0000, 1, 1'b1, 16'h0007};

    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 16'h0000; wdat = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ack",  32'(ack),  32'd0);
    check("rst_dat",  32'(rdat), 32'd0);
    check("rst_irq",  32'(irq),  32'd0);
    check("rst_gpio", 32'(gpio), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      access(tbl[i].name, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].lat, tbl[i].chk, tbl[i].e);
    end
    check("gpio_out", 32'(gpio), 32'h0000A5A5);

    // GPIO latch updates the cycle after the ack
    @(negedge clk);
    addr = 16'hFF03; we = 1'b1; wdat = 16'h5A5A; cs = 1'b1;
    @(negedge clk);
    check("gpio_t_ack", 32'(ack), 32'd1);
    check("gpio_t_old", 32'(gpio), 32'h0000A5A5);
    @(negedge clk);
    check("gpio_t_new", 32'(gpio), 32'h00005A5A);
    check("gpio_t_pulse", 32'(ack), 32'd0);
    cs = 1'b0; we = 1'b0;

    // request held for four cycles: two back-to-back accesses
    @(negedge clk);
    addr = 16'hFF03; we = 1'b0; cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ack", 32'(ack), 32'((i % 2) == 0));
      if (ack) check("b2b_dat", 32'(rdat), 32'h00005A5A);
    end
    cs = 1'b0;

    // abort by dropping cs during the wait state
    @(negedge clk);
    addr = 16'h0010; we = 1'b1; wdat = 16'hFFFF; cs = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(ack), 32'd0);
    cs = 1'b0; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_noack", 32'(ack), 32'd0);
    end
    access("abort_rd", 16'h0010, 1'b0, 16'h0000, 2, 1'b1, 16'h1234);

    // abort by reset during the wait state
    @(negedge clk);
    addr = 16'h0010; we = 1'b1; wdat = 16'h7777; cs = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ack", 32'(ack), 32'd0);
    rst = 1'b0; cs = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rstmid_ack2", 32'(ack),  32'd0);
    check("rstmid_gpio", 32'(gpio), 32'd0);
    check("rstmid_irq",  32'(irq),  32'd0);
    access("rstmid_rd", 16'h0010, 1'b0, 16'h0000, 2, 1'b1, 16'h1234);

    // timer: TCMP=3, enabled with IE; first PEND four ticks after enable
    access("tcmp3", 16'hFF01, 1'b1, 16'h0003, 1, 1'b0, 16'h0000);
    access("tctrl3", 16'hFF02, 1'b1, 16'h0003, 1, 1'b0, 16'h0000);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      check("irq_rise", 32'(irq), 32'(i == 6));
    end
    // this W1C commits on a compare-match cycle: PEND must survive
    access("w1c_tick", 16'hFF02, 1'b1, 16'h0007, 1, 1'b0, 16'h0000);
    check("pend_kept0", 32'(irq), 32'd1);
    @(negedge clk);
    check("pend_kept1", 32'(irq), 32'd1);
    repeat (2) @(negedge clk);
    // off-tick W1C clears PEND; irq drops one cycle later, returns next period
    access("w1c", 16'hFF02, 1'b1, 16'h0007, 1, 1'b0, 16'h0000);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_drop", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_low", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_again", 32'(irq), 32'd1);
    // TCOUNT write on a tick cycle wins, then keeps counting with EN=1
    access("tcnt_tick", 16'hFF00, 1'b1, 16'h0100, 1, 1'b0, 16'h0000);
    access("tcnt_tick_rd", 16'hFF00, 1'b0, 16'h0000, 1, 1'b1, 16'h0102);
    access("tctrl0", 16'hFF02, 1'b1, 16'h0000, 1, 1'b0, 16'h0000);
    access("tcnt_hold_wr", 16'hFF00, 1'b1, 16'h0100, 1, 1'b0, 16'h0000);
    access("tcnt_hold_rd", 16'hFF00, 1'b0, 16'h0000, 1, 1'b1, 16'h0100);
    access("tctrl_pend_rd", 16'hFF02, 1'b0, 16'h0000, 1, 1'b1, 16'h0004);
    check("irq_masked", 32'(irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
